instr_loader: RTL and testbench
===============================

# instr_loader

Streaming program loader that writes 9-bit machine-code words into the instruction memory's write port, filling it sequentially from address 0. It sits between a host/debug input stream and the instruction store, holding the core in reset (`cpu_hold`) while a program is being loaded.

## Interface
- `D`, 12, instruction address width; memory depth is 2**D words
- `clk` in 1 — single clock, all logic rising-edge
- `rst_n` in 1 — reset, asynchronous, active-low
- `start` in 1 — begin a load; sampled only in IDLE
- `len` in D+1 — number of words to load, sampled with `start`
- `in_valid` in 1 — input word valid
- `in_data` in 9 — input machine-code word
- `in_ready` out 1 — loader can accept a word this cycle
- `wr_en` out 1 — instruction memory write strobe
- `wr_addr` out D — write address
- `wr_data` out 9 — write data
- `busy` out 1 — load in progress (not IDLE)
- `cpu_hold` out 1 — equals `busy`; keeps the core in reset
- `done` out 1 — one-cycle pulse at load completion
- `err` out 1 — sticky: bad length or checksum mismatch; cleared by next accepted `start`

## Operation
- States: IDLE, LOAD, CHECK (only with checksum feature), DONE.
- IDLE: `start`=1 latches `len`, clears `err`, zeroes the address counter and word counter.
  - `len`=0 → DONE next cycle, no writes.
  - `len`>2**D → `err`=1, DONE next cycle, no writes.
  - Otherwise → LOAD.
- LOAD: `in_ready`=1, driven from state only, never from `in_valid`. Each handshake (`in_valid`&`in_ready`) registers `in_data` into `wr_data` and the address counter into `wr_addr`, and pulses `wr_en`; then it increments both counters. After the handshake that makes count==`len` → DONE (or CHECK).
- DONE: `done`=1 for exactly one cycle → IDLE.
- `start` is ignored while `busy`=1.
- The address counter is D bits. With `len`=2**D the final write is at address 2**D−1, and the counter wraps to 0 unused.
- `in_valid` is ignored outside LOAD/CHECK, and `in_ready`=0 there.
- Reset mid-load: immediate return to IDLE and all outputs to reset values. Memory keeps the partial contents; no recovery.

## Timing
- Reset values:
  - `in_ready`, `wr_en`, `busy`, `cpu_hold`, `done`, `err` = 0
  - `wr_addr` = 0, `wr_data` = 0
- `start` in cycle N → `busy`/`cpu_hold` high in N+1. `in_ready` is high in N+1 if the state is LOAD.
- Handshake in cycle N → `wr_en`, `wr_addr`, `wr_data` valid in N+1 (one-cycle write latency). `wr_en` is high for exactly one cycle per accepted word.
- Back-to-back handshakes give one write per cycle (full throughput).
- Last handshake in cycle N (no checksum):
  - state DONE in N+1, with `done`=1 coincident with the last `wr_en`
  - `busy`=0 in N+2
- `len`=0 or error case: `done` in N+1 after `start`, `busy`=0 in N+2.

## Configuration
- Macro: `INSTR_LOADER_CSUM_EN`.
- Defined:
  - Each loaded word is summed mod 512.
  - After the last data word the FSM enters CHECK with `in_ready`=1 and accepts one extra word, which is never written.
  - If that word ≠ sum, `err`=1.
  - Then DONE; `done` asserts one cycle after the checksum handshake.
- Not defined: there is no CHECK state, the sum logic is absent, and `err` reflects the length check only.

## Structure
- Shared package `instr_pkg`:
  - `MACH_W`=9
  - state enum `ldr_state_t` {IDLE, LOAD, CHECK, DONE}
  - `ldr_state_t` is used by the loader and by the bench.
- One sub-module: `instr_csum`, a 9-bit mod-512 accumulator with clear/add ports. It is instantiated only under `INSTR_LOADER_CSUM_EN`.

## Test plan
- Basic load: D=4, `start` with `len`=3, words 9'h0FE, 9'h0CC, 9'h1DE with continuous `in_valid` → writes (0,0FE), (1,0CC), (2,1DE) on consecutive cycles; `done` once; `busy` low 2 cycles after the last handshake.
- Stalled input: same 3 words with `in_valid` toggled every other cycle → identical write sequence, only gaps in `wr_en`, no duplicate writes.
- Boundaries:
  - `len`=0 → `done` in the next cycle, zero writes, `err`=0.
  - `len`=17 with D=4 → `err`=1, zero writes.
  - `len`=16 → the last write is at address 15.
- Reset mid-load: deassert `rst_n` after 2 of 5 words → all outputs return to 0 asynchronously. A new `start`/`len`=2 then writes addresses 0 and 1.
- `start` pulsed during LOAD → ignored; counters and `len` unchanged.
- With `INSTR_LOADER_CSUM_EN`:
  - words 9'h001, 9'h1FF, then checksum 9'h000 → `err`=0, 2 writes.
  - checksum 9'h005 → `err`=1.
  - The checksum word is never written.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared types for the instruction loader: machine word width and the loader state enum.
package instr_pkg;

  localparam int MACH_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/instr_csum.sv
// Running mod-512 sum of loaded machine words, cleared at the start of each load.
module instr_csum
  import instr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add,
  input  logic [MACH_W-1:0] din,
  output logic [MACH_W-1:0] sum
);

  logic [MACH_W-1:0] sum_q;
  logic [MACH_W-1:0] sum_d;

  // Natural 9-bit overflow gives the mod-512 wrap.
  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add) begin
      sum_d = sum_q + din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/instr_loader.sv
// Streams machine words into instruction memory from address 0, holding the core in reset meanwhile.
// Optional trailing checksum word is enabled with INSTR_LOADER_CSUM_EN.
module instr_loader
  import instr_pkg::*;
#(
  parameter int D = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [D:0]        len,
  input  logic              in_valid,
  input  logic [MACH_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [D-1:0]      wr_addr,
  output logic [MACH_W-1:0] wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output ldr_state_t        dbg_state
);

  // Handshake: a word transfers on a rising edge where in_valid & in_ready;
  // in_ready depends on state only, so a source may hold in_valid indefinitely.

  localparam logic [D:0]   CNT_ONE  = {{D{1'b0}}, 1'b1};
  localparam logic [D-1:0] ADDR_ONE = {{(D-1){1'b0}}, 1'b1};

  ldr_state_t        state_q, state_d;
  logic [D:0]        len_q, len_d;
  logic [D:0]        cnt_q, cnt_d;
  logic [D-1:0]      addr_q, addr_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [D-1:0]      wr_addr_q, wr_addr_d;
  logic [MACH_W-1:0] wr_data_q, wr_data_d;

  logic hs;
  logic last_word;
  logic len_bad;

  assign hs        = in_valid & in_ready;
  assign last_word = (cnt_q + CNT_ONE) == len_q;
  assign len_bad   = len[D] & (len[D-1:0] != '0);

`ifdef INSTR_LOADER_CSUM_EN
  logic [MACH_W-1:0] csum;

  instr_csum u_csum (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state_q == IDLE) && start),
    .add  ((state_q == LOAD) && hs),
    .din  (in_data),
    .sum  (csum)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((len == '0) || len_bad) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (hs && last_word) begin
`ifdef INSTR_LOADER_CSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef INSTR_LOADER_CSUM_EN
      CHECK: begin
        if (hs) begin
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if ((state_q == IDLE) && start) begin
      len_d  = len;
      cnt_d  = '0;
      addr_d = '0;
      err_d  = len_bad;
    end
    // Address counter wraps to 0 after a full-depth load; it is never used again.
    if ((state_q == LOAD) && hs) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = in_data;
      addr_d    = addr_q + ADDR_ONE;
      cnt_d     = cnt_q + CNT_ONE;
    end
`ifdef INSTR_LOADER_CSUM_EN
    if ((state_q == CHECK) && hs && (in_data != csum)) begin
      err_d = 1'b1;
    end
`endif
  end

  always_comb begin
    in_ready  = (state_q == LOAD) || (state_q == CHECK);
    busy      = (state_q != IDLE);
    cpu_hold  = (state_q != IDLE);
    done      = (state_q == DONE);
    err       = err_q;
    wr_en     = wr_en_q;
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader (D=4) with a transaction-level reference model and write scoreboard.
module tb_instr_loader;
  import instr_pkg::*;

  localparam int D     = 4;
  localparam int DEPTH = 1 << D;
`ifdef INSTR_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [D:0] len = '0;
  logic       in_valid = 1'b0;
  logic [8:0] in_data = '0;

  logic         in_ready, wr_en, busy, cpu_hold, done, err;
  logic [D-1:0] wr_addr;
  logic [8:0]   wr_data;
  ldr_state_t   dbg_state;

  instr_loader #(.D(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  ldr_state_t      m_st = IDLE;
  bit              m_err = 1'b0;
  bit              m_wen = 1'b0;
  int              m_left = 0;
  int              m_next = 0;
  int              m_sum = 0;
  logic [D-1:0]    m_waddr = '0;
  logic [8:0]      m_wdata = '0;
  logic [D+8:0]    exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st    = IDLE;
      m_err   = 1'b0;
      m_wen   = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      exp_q.delete();
    end else begin
      m_wen = 1'b0;
      case (m_st)
        IDLE: if (start) begin
          m_err  = 1'b0;
          m_left = int'(len);
          m_next = 0;
          m_sum  = 0;
          if (int'(len) > DEPTH) begin
            m_err = 1'b1;
            m_st  = DONE;
          end else if (len == '0) begin
            m_st = DONE;
          end else begin
            m_st = LOAD;
          end
        end
        LOAD: if (in_valid) begin
          m_wen   = 1'b1;
          m_waddr = D'(m_next % DEPTH);
          m_wdata = in_data;
          exp_q.push_back({m_waddr, in_data});
          m_next++;
          m_sum = (m_sum + int'(in_data)) % 512;
          m_left--;
          if (m_left == 0) m_st = CSUM ? CHECK : DONE;
        end
        CHECK: if (in_valid) begin
          if (int'(in_data) != m_sum) m_err = 1'b1;
          m_st = DONE;
        end
        default: m_st = IDLE;
      endcase
    end
  end

  // ---------------- compare process / scoreboard ----------------
  int         wr_cnt = 0;
  int         done_cnt = 0;
  int         last_waddr = -1;
  logic [8:0] mem[DEPTH];
  int         addr_log[$];

  always @(negedge clk) begin
    if (armed) begin
      chk("state",    32'(dbg_state), 32'(m_st));
      chk("in_ready", 32'(in_ready),  32'(m_st == LOAD || m_st == CHECK));
      chk("busy",     32'(busy),      32'(m_st != IDLE));
      chk("cpu_hold", 32'(cpu_hold),  32'(m_st != IDLE));
      chk("done",     32'(done),      32'(m_st == DONE));
      chk("err",      32'(err),       32'(m_err));
      chk("wr_en",    32'(wr_en),     32'(m_wen));
      chk("wr_addr",  32'(wr_addr),   32'(m_waddr));
      chk("wr_data",  32'(wr_data),   32'(m_wdata));
      if (wr_en) begin
        wr_cnt++;
        mem[wr_addr] = wr_data;
        last_waddr = int'(wr_addr);
        addr_log.push_back(int'(wr_addr));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_write: unexpected write addr %0h data %0h, none expected", wr_addr, wr_data);
        end else begin
          chk("sb_write", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
        end
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int l);
    @(negedge clk);
    start    = 1'b1;
    len      = (D+1)'(l);
    in_valid = 1'($urandom_range(0, 1));
    in_data  = 9'($urandom);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random gaps
  task automatic feed(input logic [8:0] words[$], input int mode, input bit poke);
    int i = 0;
    int cyc = 0;
    bit v;
    while (i < words.size() && cyc < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      in_data  = v ? words[i] : 9'($urandom);
      start    = poke && (cyc == 1);
      len      = (D+1)'($urandom);
      if (v && in_ready) i++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("feed_accepted", 32'(i), 32'(words.size()));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic load_words(input int l, input logic [8:0] w[$], input int mode,
                            input bit poke, input bit bad_csum);
    logic [8:0] words[$];
    int s = 0;
    words = w;
    foreach (w[i]) s = (s + int'(w[i])) % 512;
    if (CSUM && l >= 1 && l <= DEPTH) words.push_back(9'(bad_csum ? (s + 5) % 512 : s));
    do_start(l);
    feed(words, mode, poke);
    wait_idle();
  endtask

  task automatic run_load(input int l, input int mode, input bit bad_csum);
    logic [8:0] w[$];
    int n;
    n = (l >= 1 && l <= DEPTH) ? l : 0;
    for (int i = 0; i < n; i++) w.push_back(9'($urandom));
    load_words(l, w, mode, 1'b0, bad_csum);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(0));
    chk({tag, "_wr_en"},    32'(wr_en),    32'(0));
    chk({tag, "_busy"},     32'(busy),     32'(0));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(0));
    chk({tag, "_done"},     32'(done),     32'(0));
    chk({tag, "_err"},      32'(err),      32'(0));
    chk({tag, "_wr_addr"},  32'(wr_addr),  32'(0));
    chk({tag, "_wr_data"},  32'(wr_data),  32'(0));
  endtask

  function automatic int log_at(input int i);
    return (addr_log.size() > i) ? addr_log[i] : -1;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [8:0] basic[$];
    logic [8:0] two[$];
    int w0, d0;

    basic = '{9'h0FE, 9'h0CC, 9'h1DE};
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    #2 rst_n = 1'b0;
    armed = 1'b1;
    #1 chk_reset_outs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // basic load, continuous valid
    w0 = wr_cnt; d0 = done_cnt; addr_log.delete();
    load_words(3, basic, 0, 1'b0, 1'b0);
    chk("basic_writes", 32'(wr_cnt - w0), 32'(3));
    chk("basic_done",   32'(done_cnt - d0), 32'(1));
    chk("basic_m0", 32'(mem[0]), 32'h0FE);
    chk("basic_m1", 32'(mem[1]), 32'h0CC);
    chk("basic_m2", 32'(mem[2]), 32'h1DE);
    chk("basic_a2", 32'(log_at(2)), 32'(2));
    chk("basic_err", 32'(err), 32'(0));

    // stalled input, valid every other cycle
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    w0 = wr_cnt; addr_log.delete();
    load_words(3, basic, 1, 1'b0, 1'b0);
    chk("stall_writes", 32'(wr_cnt - w0), 32'(3));
    chk("stall_m0", 32'(mem[0]), 32'h0FE);
    chk("stall_m1", 32'(mem[1]), 32'h0CC);
    chk("stall_m2", 32'(mem[2]), 32'h1DE);
    chk("stall_a1", 32'(log_at(1)), 32'(1));

    // len = 0
    w0 = wr_cnt;
    do_start(0);
    chk("len0_done", 32'(done), 32'(1));
    chk("len0_err",  32'(err),  32'(0));
    @(negedge clk);
    chk("len0_busy", 32'(busy), 32'(0));
    chk("len0_writes", 32'(wr_cnt - w0), 32'(0));

    // len = 17 (too long)
    do_start(DEPTH + 1);
    chk("len17_done", 32'(done), 32'(1));
    chk("len17_err",  32'(err),  32'(1));
    wait_idle();
    repeat (2) @(negedge clk);
    chk("len17_err_sticky", 32'(err), 32'(1));
    chk("len17_writes", 32'(wr_cnt - w0), 32'(0));

    // len = 16 (full depth)
    w0 = wr_cnt;
    run_load(DEPTH, 2, 1'b0);
    chk("len16_writes", 32'(wr_cnt - w0), 32'(DEPTH));
    chk("len16_last",   32'(last_waddr), 32'(DEPTH - 1));
    chk("len16_err",    32'(err), 32'(0));

    // start pulsed during LOAD is ignored
    w0 = wr_cnt; addr_log.delete();
    load_words(4, '{9'h011, 9'h022, 9'h033, 9'h044}, 0, 1'b1, 1'b0);
    chk("poke_writes", 32'(wr_cnt - w0), 32'(4));
    chk("poke_a3", 32'(log_at(3)), 32'(3));

    // reset mid-load after 2 of 5 words
    two = '{9'h155, 9'h0AA};
    do_start(5);
    feed(two, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt; addr_log.delete();
    load_words(2, '{9'h003, 9'h004}, 0, 1'b0, 1'b0);
    chk("midrst_writes", 32'(wr_cnt - w0), 32'(2));
    chk("midrst_a0", 32'(log_at(0)), 32'(0));
    chk("midrst_a1", 32'(log_at(1)), 32'(1));

`ifdef INSTR_LOADER_CSUM_EN
    w0 = wr_cnt; addr_log.delete();
    load_words(2, '{9'h001, 9'h1FF}, 0, 1'b0, 1'b0);
    chk("csum_good_err",    32'(err), 32'(0));
    chk("csum_good_writes", 32'(wr_cnt - w0), 32'(2));
    w0 = wr_cnt;
    load_words(2, '{9'h001, 9'h1FF}, 2, 1'b0, 1'b1);
    chk("csum_bad_err",    32'(err), 32'(1));
    chk("csum_bad_writes", 32'(wr_cnt - w0), 32'(2));
`endif

    // randomized loads
    for (int t = 0; t < 40; t++) begin
      run_load($urandom_range(0, DEPTH + 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
